// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//
// Bundles the operand-side and result-side valid/ready handshakes of the
// bit-serial subtractor. clk and rst are not part of the bundle; they stay
// plain ports on the subtractor itself.
//
//   Operand side (driven by the producer):
//     in_valid  - A, B and Bin are valid
//     in_ready  - subtractor is idle and will take the operands
//     A, B      - minuend / subtrahend, SIZE bits
//     Bin       - borrow-in
//
//   Result side (driven by the subtractor):
//     out_valid - D and flags are valid
//     out_ready - consumer takes the result
//     D         - difference modulo 2^SIZE
//     Bout      - borrow-out (unsigned A < B + Bin)
//     Z, N, V   - zero, negative, signed overflow
//
// Modports:
//   master - the producer/consumer environment around the subtractor
//   slave  - the subtractor
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int SIZE = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] A;
    logic [SIZE-1:0] B;
    logic            Bin;

    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] D;
    logic            Bout;
    logic            Z;
    logic            N;
    logic            V;

    modport master (
        output in_valid,
        output A,
        output B,
        output Bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  D,
        input  Bout,
        input  Z,
        input  N,
        input  V
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  Bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output D,
        output Bout,
        output Z,
        output N,
        output V
    );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first, with
// a single borrow flip-flop carried from bit to bit. Also reports borrow-out
// and zero / negative / signed-overflow flags for compare and branch logic.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-high reset; aborts any operation in flight
//   bus  - serial_subtractor_if.slave: operand handshake (in_valid/in_ready,
//          A, B, Bin) and result handshake (out_valid/out_ready, D, Bout,
//          Z, N, V)
//
// Flow:
//   IDLE  : in_ready=1. An in_valid edge loads the operand shift registers,
//           the borrow flip-flop (with Bin) and clears the bit counter.
//   SHIFT : SIZE cycles, one difference bit per cycle. The result and flags
//           are registered on the edge that processes the last bit.
//   DONE  : out_valid=1, result held until out_ready; then back to IDLE.
//
// Timing: result visible SIZE cycles after the accept edge; one operation
// per SIZE+2 cycles at best. in_ready and out_valid are never both high.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int SIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    // Counter must be able to hold SIZE so that SIZE=1 still gets one bit.
    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [CW-1:0]   cnt_q;
    logic [SIZE-1:0] a_sr;
    logic [SIZE-1:0] b_sr;
    logic [SIZE-1:0] d_sr;
    logic            br_q;

    // Operand sign bits are kept aside because the shift registers no
    // longer hold them by the time the overflow flag is computed.
    logic            a_msb_q;
    logic            b_msb_q;

    logic [SIZE-1:0] d_q;
    logic            bout_q;
    logic            z_q;
    logic            n_q;
    logic            v_q;

    logic            in_ready_c;
    logic            out_valid_c;

    logic            a_bit;
    logic            b_bit;
    logic            d_bit;
    logic            br_next;
    logic            last_bit;
    logic [SIZE-1:0] d_next;

    // -----------------------------------------------------------------------
    // Full-subtractor bit slice.
    // -----------------------------------------------------------------------
    function automatic logic diff_bit(input logic a, input logic b,
                                      input logic br);
        return a ^ b ^ br;
    endfunction

    function automatic logic borrow_next(input logic a, input logic b,
                                         input logic br);
        return (~a & b) | (~a & br) | (b & br);
    endfunction

    // Insert the new difference bit at the MSB while the older bits move
    // toward the LSB. Written with shifts rather than a concatenation so
    // that SIZE=1 needs no zero-width slice.
    function automatic logic [SIZE-1:0] shift_in_msb(input logic [SIZE-1:0] v,
                                                     input logic bit_in);
        return (v >> 1) | (SIZE'(bit_in) << (SIZE - 1));
    endfunction

    assign a_bit    = a_sr[0];
    assign b_bit    = b_sr[0];
    assign d_bit    = diff_bit(a_bit, b_bit, br_q);
    assign br_next  = borrow_next(a_bit, b_bit, br_q);
    assign d_next   = shift_in_msb(d_sr, d_bit);
    assign last_bit = (cnt_q == CW'(SIZE - 1));

    // -----------------------------------------------------------------------
    // Control FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM: next state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: operand capture, bit-serial shift, result/flag registers.
    // Result registers load only on the last SHIFT edge, so they stay
    // stable through DONE stalls and after the handshake.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            d_sr    <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr    <= bus.A;
                        b_sr    <= bus.B;
                        d_sr    <= '0;
                        br_q    <= bus.Bin;
                        cnt_q   <= '0;
                        a_msb_q <= bus.A[SIZE-1];
                        b_msb_q <= bus.B[SIZE-1];
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    d_sr  <= d_next;
                    br_q  <= br_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        d_q    <= d_next;
                        bout_q <= br_next;
                        z_q    <= (d_next == '0);
                        n_q    <= d_next[SIZE-1];
                        v_q    <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_next[SIZE-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.D         = d_q;
    assign bus.Bout      = bout_q;
    assign bus.Z         = z_q;
    assign bus.N         = n_q;
    assign bus.V         = v_q;

endmodule
